// File: rtl/char_classifier_if.sv
// Byte-stream interface for char_classifier.
// The slave modport is the classifier's view: it takes the incoming bytes plus
// the downstream stall, and it drives the classified output stream.
interface char_classifier_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       stall;
    logic       shift_en;
    logic [7:0] data_out;
    logic       is_number_out;
    logic       is_white_out;
    logic       number_done;
    logic [3:0] run_len;

    modport master (
        output rx_data, rx_valid, stall,
        input  rx_ready, shift_en, data_out, is_number_out, is_white_out,
               number_done, run_len
    );

    modport slave (
        input  rx_data, rx_valid, stall,
        output rx_ready, shift_en, data_out, is_number_out, is_white_out,
               number_done, run_len
    );
endinterface

// File: rtl/char_classifier.sv
// char_classifier: tags incoming bytes as number / whitespace, buffers them in
// a small FIFO and feeds a downstream shift chain one byte per cycle unless it
// is stalled. It also counts runs of number bytes and reports each run length
// when the run is terminated by a non-number byte.
// Optional feature: define CLASSIFY_HEX_EN to also treat A-F / a-f as number.
module char_classifier #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    char_classifier_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // FIFO entry: {is_white, is_number, byte}
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          wr_en;
    logic          rd_en;
    logic          in_num;
    logic          in_white;
    logic [9:0]    rd_entry;

    logic [3:0]    run_cnt;
    logic          shift_en_r;
    logic [7:0]    data_out_r;
    logic          is_num_r;
    logic          is_white_r;
    logic          done_r;
    logic [3:0]    run_len_r;

    // Ready depends only on occupancy (and reset), never on the same-cycle
    // pop, so a full FIFO does not accept a byte even while it drains.
    assign bus.rx_ready = !rst && (count != FULL_CNT);
    assign wr_en        = bus.rx_valid && bus.rx_ready;
    // Pop sees the occupancy before this cycle's write, so a byte written into
    // an empty FIFO waits one cycle before it can leave.
    assign rd_en        = (count != '0) && !bus.stall;
    assign rd_entry     = mem[rd_ptr];

    // Classify the incoming byte so flags are stored alongside it.
    always_comb begin
        in_num   = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
`ifdef CLASSIFY_HEX_EN
        if (((bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h46)) ||
            ((bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h66)))
            in_num = 1'b1;
`endif
        in_white = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h09) ||
                   (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h0D);
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {in_white, in_num, bus.rx_data};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output stage and run tracking: a pop registers the byte and strobes the
    // shift chain next cycle; run_len only changes when a run is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_en_r <= 1'b0;
            data_out_r <= 8'h00;
            is_num_r   <= 1'b0;
            is_white_r <= 1'b0;
            done_r     <= 1'b0;
            run_len_r  <= 4'd0;
            run_cnt    <= 4'd0;
        end else if (rd_en) begin
            shift_en_r <= 1'b1;
            data_out_r <= rd_entry[7:0];
            is_num_r   <= rd_entry[8];
            is_white_r <= rd_entry[9];
            if (rd_entry[8]) begin
                done_r <= 1'b0;
                if (run_cnt != 4'hF)
                    run_cnt <= run_cnt + 4'd1;
            end else if (run_cnt != 4'd0) begin
                done_r    <= 1'b1;
                run_len_r <= run_cnt;
                run_cnt   <= 4'd0;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            shift_en_r <= 1'b0;
            done_r     <= 1'b0;
        end
    end

    assign bus.shift_en      = shift_en_r;
    assign bus.data_out      = data_out_r;
    assign bus.is_number_out = is_num_r;
    assign bus.is_white_out  = is_white_r;
    assign bus.number_done   = done_r;
    assign bus.run_len       = run_len_r;
endmodule

// File: tb/tb_char_classifier.sv
// Bench for char_classifier: a queue-based reference model is compared against
// every output on every falling edge, plus directed sequences with literal
// expectations and a randomized stream with occasional resets.
module tb_char_classifier;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    char_classifier_if bus();

    char_classifier #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit f_num(input logic [7:0] b);
`ifdef CLASSIFY_HEX_EN
        return b inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]};
`else
        return b inside {[8'h30:8'h39]};
`endif
    endfunction

    function automatic bit f_white(input logic [7:0] b);
        return b inside {8'h20, 8'h09, 8'h0A, 8'h0D};
    endfunction

`ifdef CLASSIFY_HEX_EN
    localparam logic HEX_A_NUM = 1'b1;
`else
    localparam logic HEX_A_NUM = 1'b0;
`endif

    // Reference model: a byte queue plus the last presented byte and run state.
    logic [7:0] q[$];
    logic       m_shift = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_num   = 1'b0;
    logic       m_white = 1'b0;
    logic       m_done  = 1'b0;
    int         m_len   = 0;
    int         m_run   = 0;

    always @(posedge clk or posedge rst) begin
        bit pop, push;
        logic [7:0] b;
        if (rst) begin
            q.delete();
            m_shift = 1'b0; m_data = 8'h00; m_num = 1'b0; m_white = 1'b0;
            m_done = 1'b0; m_len = 0; m_run = 0;
        end else begin
            pop  = (q.size() > 0) && !bus.stall;
            push = bus.rx_valid && (q.size() < DEPTH);
            m_done = 1'b0;
            m_shift = pop;
            if (pop) begin
                b = q.pop_front();
                m_data = b; m_num = f_num(b); m_white = f_white(b);
                if (m_num) m_run = (m_run < 15) ? m_run + 1 : 15;
                else if (m_run > 0) begin
                    m_done = 1'b1; m_len = m_run; m_run = 0;
                end
            end
            if (push) q.push_back(bus.rx_data);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("rx_ready", bus.rx_ready, (!rst && q.size() < DEPTH));
        chk("shift_en", bus.shift_en, m_shift);
        chk("data_out", bus.data_out, m_data);
        chk("is_number_out", bus.is_number_out, m_num);
        chk("is_white_out", bus.is_white_out, m_white);
        chk("number_done", bus.number_done, m_done);
        chk("run_len", bus.run_len, m_len);
    end

    // Drive inputs just after a falling edge, return at the next falling edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic s);
        #1;
        bus.rx_valid = v; bus.rx_data = d; bus.stall = s;
        @(negedge clk);
    endtask

    logic [7:0] got_q[$];
    int ndone, last_len, nshift;

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.stall = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_run_len", bus.run_len, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_rx_ready", bus.rx_ready, 1);

        // "12 " with no stall; also first-write latency
        cyc(1'b1, 8'h31, 1'b0);
        chk("lat_shift_after_write_edge", bus.shift_en, 0);
        cyc(1'b1, 8'h32, 1'b0);
        chk("lat_shift_second_edge", bus.shift_en, 1);
        chk("s12_d0", bus.data_out, 8'h31);
        chk("s12_f0", {bus.is_number_out, bus.is_white_out}, 2'b10);
        cyc(1'b1, 8'h20, 1'b0);
        chk("s12_sh1", bus.shift_en, 1);
        chk("s12_d1", bus.data_out, 8'h32);
        chk("s12_f1", {bus.is_number_out, bus.is_white_out}, 2'b10);
        cyc(1'b0, 8'h00, 1'b0);
        chk("s12_sh2", bus.shift_en, 1);
        chk("s12_d2", bus.data_out, 8'h20);
        chk("s12_f2", {bus.is_number_out, bus.is_white_out}, 2'b01);
        chk("s12_done", bus.number_done, 1);
        chk("s12_len", bus.run_len, 2);
        cyc(1'b0, 8'h00, 1'b0);
        chk("s12_idle_shift", bus.shift_en, 0);
        chk("s12_len_hold", bus.run_len, 2);

        // Fill under stall, fifth byte refused, then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b1);
        chk("full_rx_ready", bus.rx_ready, 0);
        cyc(1'b1, 8'h54, 1'b1);
        chk("full_hold_ready", bus.rx_ready, 0);
        chk("full_no_shift", bus.shift_en, 0);
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            if (bus.shift_en) got_q.push_back(bus.data_out);
        end
        chk("drain_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("drain_order", (i < got_q.size()) ? got_q[i] : 8'hXX, 8'h50 + 8'(i));

        // Saturating run of 20 digits terminated by newline
        ndone = 0; last_len = 0;
        for (int i = 0; i < 27; i++) begin
            if (i < 20) cyc(1'b1, 8'h37, 1'b0);
            else if (i == 20) cyc(1'b1, 8'h0A, 1'b0);
            else cyc(1'b0, 8'h00, 1'b0);
            if (bus.number_done) begin ndone++; last_len = bus.run_len; end
        end
        chk("sat_done_count", ndone, 1);
        chk("sat_run_len", last_len, 15);

        // Reset in the middle of a digit run discards it
        cyc(1'b1, 8'h34, 1'b0);
        #1 bus.rx_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mid_rst_shift", bus.shift_en, 0);
        chk("mid_rst_done", bus.number_done, 0);
        chk("mid_rst_data", bus.data_out, 8'h00);
        chk("mid_rst_flags", {bus.is_number_out, bus.is_white_out}, 2'b00);
        chk("mid_rst_len", bus.run_len, 0);
        chk("mid_rst_ready", bus.rx_ready, 0);
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        ndone = 0; nshift = 0;
        for (int i = 0; i < 6; i++) begin
            cyc((i == 0), 8'h78, 1'b0);
            if (bus.number_done) ndone++;
            if (bus.shift_en) nshift++;
        end
        chk("post_rst_no_done", ndone, 0);
        chk("post_rst_x_shift", nshift, 1);

        // 'A' classification
        cyc(1'b1, 8'h41, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("hexA_shift", bus.shift_en, 1);
        chk("hexA_data", bus.data_out, 8'h41);
        chk("hexA_num", bus.is_number_out, HEX_A_NUM);
        chk("hexA_white", bus.is_white_out, 0);
        cyc(1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
                0, 1: d = 8'h30 + 8'($urandom_range(0, 9));
                2: begin
                    case ($urandom_range(0, 3))
                        0: d = 8'h20; 1: d = 8'h09; 2: d = 8'h0A; default: d = 8'h0D;
                    endcase
                end
                3: d = ($urandom_range(0, 1) ? 8'h41 : 8'h61) + 8'($urandom_range(0, 6));
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
            end else begin
                cyc(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/char_classifier.md
CHAR_CLASSIFIER -- requirements
Module: char_classifier

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  received byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid this cycle.
REQ-006 SHALL have port rx_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port stall  input  1  downstream shift chain must not advance.
REQ-008 SHALL have port shift_en  output  1  one-cycle advance strobe for the downstream shift chain.
REQ-009 SHALL have port data_out  output  8  classified byte presented with shift_en.
REQ-010 SHALL have port is_number_out  output  1  data_out is a number character.
REQ-011 SHALL have port is_white_out  output  1  data_out is whitespace.
REQ-012 SHALL have port number_done  output  1  one-cycle pulse: digit run ended.
REQ-013 SHALL have port run_len  output  4  length of the run that just ended; valid with number_done.

Function
REQ-014 SHALL classify at FIFO write: is_number = rx_data in 0x30..0x39; is_white = rx_data in {0x20, 0x09, 0x0A, 0x0D}; both flags stored with the byte.
REQ-015 SHALL accept a byte (write) when rx_valid && rx_ready; rx_ready = FIFO not full, combinational from occupancy only.
REQ-016 SHALL pop one entry per cycle when FIFO not empty and stall low; pop registers data_out/is_number_out/is_white_out and asserts shift_en the next cycle (1-cycle latency pop->shift_en).
REQ-017 SHALL hold data_out and flags unchanged when no pop occurs; shift_en low in those cycles.
REQ-018 SHALL support simultaneous write and pop when full: pop frees a slot but rx_ready stays low that cycle (no write-through when full).
REQ-019 SHALL support simultaneous write and pop when empty: the written byte is not popped until the following cycle (no bypass).
REQ-020 SHALL use wrap-around read/write pointers with an occupancy counter of width clog2(DEPTH)+1; occupancy never exceeds DEPTH nor underflows.
REQ-021 SHALL keep run counter: increments on each popped number byte, saturating at 15.
REQ-022 SHALL, on popping a non-number byte while run counter > 0, pulse number_done together with that byte's shift_en, drive run_len = counter value, and clear the counter.
REQ-023 SHALL keep run_len stable between number_done pulses.
REQ-024 SHALL treat stall asserted mid-run as a pause only: run counter and FIFO contents retained.

Reset
REQ-025 SHALL, on rst high, asynchronously clear pointers, occupancy, run counter; shift_en=0, number_done=0, data_out=0x00, is_number_out=0, is_white_out=0, run_len=0.
REQ-026 SHALL drive rx_ready=0 while rst is high and rx_ready=1 in the first cycle after release.
REQ-027 SHALL discard all buffered bytes and any partial digit run when reset occurs mid-operation; no number_done for the discarded run.

Configuration
REQ-028 SHALL, when macro CLASSIFY_HEX_EN is defined, additionally classify 0x41..0x46 and 0x61..0x66 as number; without it only 0x30..0x39 are number.

Verification
REQ-029 SHALL verify: stream "12 " with stall=0 -> shift_en on 3 consecutive cycles, flags (1,0),(1,0),(0,1); number_done with the space, run_len=2.
REQ-030 SHALL verify: stall=1, push 5 bytes with DEPTH=4 -> first 4 accepted, rx_ready=0 on 5th; release stall -> 4 shift_en pulses in byte order.
REQ-031 SHALL verify: 20 consecutive '7' then 0x0A -> run_len=15 (saturated), single number_done.
REQ-032 SHALL verify: push "4", assert rst before next byte -> all outputs at reset values, no number_done afterwards for following "x".
REQ-033 SHALL verify: byte 0x41 ('A') -> is_number_out=1 with CLASSIFY_HEX_EN, 0 without; is_white_out=0 in both.
REQ-034 SHALL verify: write into empty FIFO with stall=0 -> shift_en exactly 2 cycles after the write edge.
